// File: rtl/led_pwm_pkg.sv
// Shared constants and width helpers for the LED PWM driver.
package led_pwm_pkg;

  localparam int DEFAULT_DUTY_W = 8;

  // Last period-counter value; a full-scale duty always compares above it.
  function automatic int pmax(input int duty_w);
    return (1 << duty_w) - 2;
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler plus PWM period counter; flags the period-boundary load cycle.
module led_pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int DUTY_W   = DEFAULT_DUTY_W,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              tick,
  output logic [DUTY_W-1:0] pcnt,
  output logic              load
);

  localparam int                PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] PCNT_MAX  = DUTY_W'(pmax(DUTY_W));

  logic [PW-1:0] presc;

  assign tick = (presc == PRESC_MAX);
  assign load = tick && (pcnt == PCNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (load)
        pcnt <= '0;
      else if (tick)
        pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// Eight-channel double-buffered PWM LED driver. The board wrapper maps
// oLed[5:0] to bMKR_D[5:0] and oLed[7:6] to bMKR_D[14:13].
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int DUTY_W   = DEFAULT_DUTY_W,
  parameter int PRESCALE = 4,
  parameter int CH_W     = ch_w(NUM_CH)
) (
  input  logic              wClk,
  input  logic              wRst,
  input  logic              iWrEn,
  input  logic [CH_W-1:0]   iWrCh,
  input  logic [DUTY_W-1:0] iWrDuty,
  output logic              oWrReady,
  output logic [NUM_CH-1:0] oLed,
  output logic              oPeriodStart
);

  localparam int                CHC_W    = CH_W + 1;
  localparam logic [DUTY_W-1:0] PCNT_MAX = DUTY_W'(pmax(DUTY_W));

  logic              tick;
  logic              load;
  logic [DUTY_W-1:0] pcnt;
  logic              wr_fire;

  logic [DUTY_W-1:0] shadow [NUM_CH];
  logic [DUTY_W-1:0] active [NUM_CH];

  led_pwm_timebase #(
    .DUTY_W   (DUTY_W),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk  (wClk),
    .rst  (wRst),
    .tick (tick),
    .pcnt (pcnt),
    .load (load)
  );

  // Refusing writes in the load cycle keeps shadow stable while it is copied.
  assign oWrReady = !wRst && !(tick && (pcnt == PCNT_MAX));
  assign wr_fire  = iWrEn && oWrReady;

  // NOTE: the duty banks are small flop arrays, not RAM, so they are reset
  // like any other register; a reset must never leave a stale duty behind.
  always_ff @(posedge wClk) begin
    if (wRst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      oLed         <= '0;
      oPeriodStart <= 1'b0;
    end else begin
      oPeriodStart <= load;
      for (int i = 0; i < NUM_CH; i++) begin
        // Out-of-range channel numbers match no slot and are dropped.
        if (wr_fire && ({1'b0, iWrCh} == CHC_W'(i)))
          shadow[i] <= iWrDuty;
        if (load)
          active[i] <= shadow[i];
        oLed[i] <= (pcnt < active[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver: table vectors, period measurements
// and a randomized phase against a cycle-position reference model.
module tb_led_pwm_driver;

  localparam int NUM_CH   = 8;
  localparam int DUTY_W   = 8;
  localparam int PRESCALE = 4;
  localparam int CH_W     = 4;
  localparam int PERIOD   = ((1 << DUTY_W) - 1) * PRESCALE;

  logic              wClk = 1'b0;
  logic              wRst = 1'b1;
  logic              iWrEn = 1'b0;
  logic [CH_W-1:0]   iWrCh = '0;
  logic [DUTY_W-1:0] iWrDuty = '0;
  logic              oWrReady;
  logic [NUM_CH-1:0] oLed;
  logic              oPeriodStart;

  led_pwm_driver #(
    .NUM_CH   (NUM_CH),
    .DUTY_W   (DUTY_W),
    .PRESCALE (PRESCALE),
    .CH_W     (CH_W)
  ) dut (
    .wClk         (wClk),
    .wRst         (wRst),
    .iWrEn        (iWrEn),
    .iWrCh        (iWrCh),
    .iWrDuty      (iWrDuty),
    .oWrReady     (oWrReady),
    .oLed         (oLed),
    .oPeriodStart (oPeriodStart)
  );

  always #5 wClk = ~wClk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: position inside the 1020-cycle period plus duty banks.
  int              m_pos;
  int              m_shadow [NUM_CH];
  int              m_active [NUM_CH];
  logic [NUM_CH-1:0] m_led;
  logic            m_ps;

  task automatic model_edge(input bit r, input bit acc, input int ch, input int duty);
    bit ld;
    int level;
    if (r) begin
      m_pos = 0;
      m_led = '0;
      m_ps  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
    end else begin
      ld    = (m_pos == PERIOD - 1);
      level = m_pos / PRESCALE;
      for (int i = 0; i < NUM_CH; i++)
        m_led[i] = (level < m_active[i]);
      if (ld)
        for (int i = 0; i < NUM_CH; i++)
          m_active[i] = m_shadow[i];
      if (acc && ch < NUM_CH)
        m_shadow[ch] = duty;
      m_ps  = ld;
      m_pos = ld ? 0 : m_pos + 1;
    end
  endtask

  // Driver state: a pending write is held on the port until accepted.
  bit   rst_q = 1'b1;
  bit   pend  = 1'b0;
  int   pend_ch = 0;
  int   pend_duty = 0;
  logic dut_ready;
  int   cyc = 0;

  task automatic step();
    bit en;
    bit rdy;
    en      = pend;
    wRst    = rst_q;
    iWrEn   = en;
    iWrCh   = CH_W'(pend_ch);
    iWrDuty = DUTY_W'(pend_duty);
    #1;
    rdy       = !rst_q && (m_pos != PERIOD - 1);
    dut_ready = oWrReady;
    check("ready", oWrReady, rdy);
    @(posedge wClk);
    model_edge(rst_q, en && rdy, pend_ch, pend_duty);
    if (en && rdy) pend = 1'b0;
    cyc = rst_q ? 0 : cyc + 1;
    #1;
    check("led", oLed, m_led);
    check("period_start", oPeriodStart, m_ps);
  endtask

  task automatic post_write(input int ch, input int duty);
    pend      = 1'b1;
    pend_ch   = ch;
    pend_duty = duty;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    while (oPeriodStart !== 1'b1 && n < 2 * PERIOD) begin
      step();
      n++;
    end
    check("ps_timeout", oPeriodStart, 1);
  endtask

  int hi [NUM_CH];
  bit led0_seen = 1'b0;
  bit led1_drop = 1'b0;
  logic coll_ready;

  // Starts in a period-start cycle and ends in the next one.
  task automatic measure(input int wr_pos, input int wr_ch, input int wr_duty);
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k == wr_pos) post_write(wr_ch, wr_duty);
      step();
      if (k == wr_pos) coll_ready = dut_ready;
      for (int i = 0; i < NUM_CH; i++) hi[i] += int'(oLed[i]);
      if (oLed[0]) led0_seen = 1'b1;
      if (!oLed[1]) led1_drop = 1'b1;
    end
    check("period_len", oPeriodStart, 1);
  endtask

  task automatic check_hi(input string tag, input int e0, input int e1, input int e2,
                          input int e3, input int e4);
    int e [NUM_CH];
    e = '{e0, e1, e2, e3, e4, 0, 0, 0};
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("%s_ch%0d_high", tag, i), hi[i], e[i]);
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    int         ch;
    int         duty;
    bit         exp_ready;
    bit         exp_ps;
    logic [7:0] exp_led;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b0, 0,   0, 1'b0, 1'b0, 8'h00},
      '{1'b0, 1'b1, 0,   0, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1, 255, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 9,  77, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 2, 128, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 3,  64, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 4,  40, 1'b1, 1'b0, 8'h00}
    };
    model_edge(1'b1, 1'b0, 0, 0);

    // Reset hold and initial writes, including a discarded channel 9.
    foreach (tbl[v]) begin
      rst_q = tbl[v].rst;
      if (tbl[v].en) post_write(tbl[v].ch, tbl[v].duty);
      step();
      check($sformatf("tbl%0d_ready", v), dut_ready, tbl[v].exp_ready);
      check($sformatf("tbl%0d_led", v), oLed, tbl[v].exp_led);
      check($sformatf("tbl%0d_ps", v), oPeriodStart, tbl[v].exp_ps);
    end

    wait_ps();
    check("first_load_cycle", cyc, PERIOD);

    // Period 1: ch3 rewritten mid-period keeps its old duty.
    measure(500, 3, 200);
    check_hi("p1", 0, 1020, 512, 256, 160);
    // Period 2: ch3 new duty; write to ch4 held across the load cycle.
    measure(PERIOD - 1, 4, 10);
    check("collision_ready", coll_ready, 0);
    check_hi("p2", 0, 1020, 512, 800, 160);
    // Period 3: collided write landed in this period, not yet active.
    measure(-1, 0, 0);
    check_hi("p3", 0, 1020, 512, 800, 160);
    measure(-1, 0, 0);
    check_hi("p4", 0, 1020, 512, 800, 40);
    check("ch0_never_on", led0_seen, 0);
    check("ch1_always_on", led1_drop, 0);

    // Reset mid-period clears every duty.
    repeat (300) step();
    rst_q = 1'b1;
    repeat (2) step();
    check("midrst_led", oLed, 0);
    check("midrst_ps", oPeriodStart, 0);
    check("midrst_ready", dut_ready, 0);
    rst_q = 1'b0;
    wait_ps();
    check("reload_after_reset", cyc, PERIOD);
    measure(-1, 0, 0);
    check_hi("post_rst", 0, 0, 0, 0, 0);

    // Randomized traffic, with writes forced onto the load cycle too.
    for (int n = 0; n < 3000; n++) begin
      rst_q = ($urandom_range(0, 999) == 0);
      if (!pend && ($urandom_range(0, 3) == 0 || m_pos == PERIOD - 1)) begin
        case ($urandom_range(0, 3))
          0:       post_write($urandom_range(0, 15), 0);
          1:       post_write($urandom_range(0, 15), 255);
          default: post_write($urandom_range(0, 15), $urandom_range(0, 255));
        endcase
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
